// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate L1 data cache.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   Dmem2proc_response/tag  memory accept tag and returning-data tag (0 = none)
//   Dmem2proc_data          fill data from memory
//   proc2Dcache_*           processor request: command, byte address, store data
//   mem_size                access size (byte/half/word/double)
//   proc2Dmem_*             memory command, block address and writeback data
//   Dcache_data_out/valid   zero-extended load result and its valid flag
//   finished                request completes this cycle
//   show_dcache_data        {valid, dirty, tag, data} per line, zero when TEST_MODE=0
module dcache_wb #(
   parameter int XLEN         = 32,
   parameter int DCACHE_LINES = 32,
   parameter int BLOCK_BYTES  = 8,
   parameter bit TEST_MODE    = 1'b1,
   localparam int IDXW = $clog2(DCACHE_LINES),
   localparam int OFFW = $clog2(BLOCK_BYTES),
   localparam int TAGW = XLEN - IDXW - OFFW
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [3:0]                        Dmem2proc_response,
   input  logic [63:0]                       Dmem2proc_data,
   input  logic [3:0]                        Dmem2proc_tag,
   input  logic [XLEN-1:0]                   proc2Dcache_addr,
   input  logic [63:0]                       proc2Dcache_data,
   input  logic [1:0]                        proc2Dcache_command,
   input  logic [1:0]                        mem_size,
   output logic [1:0]                        proc2Dmem_command,
   output logic [XLEN-1:0]                   proc2Dmem_addr,
   output logic [63:0]                       proc2Dmem_data,
   output logic [63:0]                       Dcache_data_out,
   output logic                              Dcache_valid_out,
   output logic                              finished,
   output logic [DCACHE_LINES-1:0][TAGW+65:0] show_dcache_data
);
   typedef enum logic [1:0] {IDLE, WB, FETCH, WAIT} state_t;
   state_t state_q, state_d;
   logic [DCACHE_LINES-1:0] valid_q, dirty_q;
   logic [TAGW-1:0] tags_q [DCACHE_LINES];
   logic [63:0] data_q [DCACHE_LINES];
   logic [IDXW-1:0] lidx_q, lidx_d;
   logic [TAGW-1:0] ltag_q, ltag_d;
   logic [3:0] pend_q, pend_d;
   logic [OFFW-1:0] off, off_al;
   logic [IDXW-1:0] idx;
   logic [TAGW-1:0] tag;
   logic [5:0] sh;
   logic [63:0] mask, blk, merged;
   logic hit, fill;
   assign {tag, idx, off} = proc2Dcache_addr;
   always_comb begin
      // clear offset bits below the access size to force natural alignment
      off_al = off & ~((OFFW'(1) << mem_size) - OFFW'(1));
      sh = {off_al, 3'b000};
      mask = (mem_size == 2'd3) ? {64{1'b1}} : (64'd1 << (7'd8 << mem_size)) - 64'd1;
      blk = data_q[idx];
      merged = (blk & ~(mask << sh)) | ((proc2Dcache_data & mask) << sh);
      // requests are only evaluated in IDLE so a changed request cannot disturb a miss in flight
      hit = (state_q == IDLE) && valid_q[idx] && (tags_q[idx] == tag) && (proc2Dcache_command != 2'd0);
      fill = (state_q == WAIT) && (pend_q != 4'd0) && (Dmem2proc_tag == pend_q);
      finished = hit;
      Dcache_valid_out = hit && (proc2Dcache_command == 2'd1);
      Dcache_data_out = Dcache_valid_out ? (blk >> sh) & mask : 64'd0;
   end
   always_comb begin
      state_d = state_q;
      lidx_d = lidx_q;
      ltag_d = ltag_q;
      pend_d = pend_q;
      proc2Dmem_command = 2'd0;
      proc2Dmem_addr = '0;
      proc2Dmem_data = '0;
      case (state_q)
         IDLE: if (proc2Dcache_command != 2'd0 && !hit) begin
            lidx_d = idx;
            ltag_d = tag;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FETCH;
         end
         WB: begin
            proc2Dmem_command = 2'd2;
            proc2Dmem_addr = {tags_q[lidx_q], lidx_q, {OFFW{1'b0}}};
            proc2Dmem_data = data_q[lidx_q];
            if (Dmem2proc_response != 4'd0) state_d = FETCH;
         end
         FETCH: begin
            proc2Dmem_command = 2'd1;
            proc2Dmem_addr = {ltag_q, lidx_q, {OFFW{1'b0}}};
            if (Dmem2proc_response != 4'd0) begin
               pend_d = Dmem2proc_response;
               state_d = WAIT;
            end
         end
         default: if (fill) begin
            pend_d = 4'd0;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         lidx_q <= '0;
         ltag_q <= '0;
         pend_q <= '0;
      end else begin
         state_q <= state_d;
         lidx_q <= lidx_d;
         ltag_q <= ltag_d;
         pend_q <= pend_d;
      end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < DCACHE_LINES; i++) begin
            tags_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (hit && proc2Dcache_command == 2'd2) begin
            data_q[idx] <= merged;
            dirty_q[idx] <= 1'b1;
         end
         if (state_q == WB && Dmem2proc_response != 4'd0) dirty_q[lidx_q] <= 1'b0;
         if (fill) begin
            valid_q[lidx_q] <= 1'b1;
            dirty_q[lidx_q] <= 1'b0;
            tags_q[lidx_q] <= ltag_q;
            data_q[lidx_q] <= Dmem2proc_data;
         end
      end
   for (genvar g = 0; g < DCACHE_LINES; g++) begin : g_show
      assign show_dcache_data[g] = TEST_MODE ? {valid_q[g], dirty_q[g], tags_q[g], data_q[g]} : '0;
   end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed vectors plus randomized requests against a flat-memory reference.
module tb_dcache_wb;
   logic clock = 1'b0, reset = 1'b0;
   logic [3:0] Dmem2proc_response = '0, Dmem2proc_tag = '0;
   logic [63:0] Dmem2proc_data = '0, proc2Dcache_data = '0;
   logic [31:0] proc2Dcache_addr = '0;
   logic [1:0] proc2Dcache_command = '0, mem_size = '0;
   logic [1:0] proc2Dmem_command;
   logic [31:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data, Dcache_data_out;
   logic Dcache_valid_out, finished;
   logic [31:0][89:0] show_dcache_data;
   dcache_wb dut (
      .clock(clock), .reset(reset),
      .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data), .Dmem2proc_tag(Dmem2proc_tag),
      .proc2Dcache_addr(proc2Dcache_addr), .proc2Dcache_data(proc2Dcache_data),
      .proc2Dcache_command(proc2Dcache_command), .mem_size(mem_size),
      .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
      .Dcache_data_out(Dcache_data_out), .Dcache_valid_out(Dcache_valid_out), .finished(finished),
      .show_dcache_data(show_dcache_data)
   );
   always #5 clock = ~clock;
   typedef struct packed {logic [1:0] c; logic [31:0] a; logic [63:0] d;} tr_t;
   typedef struct {
      logic [1:0] cmd; logic [31:0] addr; logic [1:0] size; logic [63:0] wd;
      logic hit; logic [63:0] out; int ntr; tr_t t0, t1; logic [89:0] line;
   } vec_t;
   int n_cmp = 0, n_bad = 0;
   tr_t tr_q[$];
   logic [63:0] bk [logic [31:0]];
   logic [63:0] fm [logic [31:0]];
   logic [3:0] tag_ctr = 4'd1, ret_tag = 4'd0;
   logic [63:0] ret_data = '0;
   int ret_cnt = 0, force_lat = 0;
   logic m_v [32], m_d [32];
   logic [23:0] m_t [32];
   vec_t vt [13];
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [63:0] init_blk(input logic [31:0] a);
      return {a ^ 32'h5A5A_0000, ~a};
   endfunction
   function automatic logic [63:0] bk_get(input logic [31:0] a);
      return bk.exists(a) ? bk[a] : init_blk(a);
   endfunction
   function automatic logic [63:0] fm_get(input logic [31:0] a);
      return fm.exists(a) ? fm[a] : init_blk(a);
   endfunction
   function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] s);
      return a & ~((32'd1 << s) - 32'd1);
   endfunction
   function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [1:0] s);
      logic [63:0] r = '0, b;
      logic [31:0] ba;
      for (int k = 0; k < (1 << s); k++) begin
         ba = align(a, s) + k;
         b = fm_get(ba & ~32'd7);
         r[8*k +: 8] = b[8*ba[2:0] +: 8];
      end
      return r;
   endfunction
   task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [63:0] wd);
      logic [63:0] b;
      logic [31:0] ba;
      for (int k = 0; k < (1 << s); k++) begin
         ba = align(a, s) + k;
         b = fm_get(ba & ~32'd7);
         b[8*ba[2:0] +: 8] = wd[8*k +: 8];
         fm[ba & ~32'd7] = b;
      end
   endtask
   task automatic mem_step();
      logic [3:0] t;
      Dmem2proc_response = '0;
      Dmem2proc_tag = '0;
      Dmem2proc_data = '0;
      if (ret_cnt > 0) begin
         ret_cnt--;
         if (ret_cnt == 0) begin
            Dmem2proc_tag = ret_tag;
            Dmem2proc_data = ret_data;
         end
      end
      if (Dmem2proc_tag == 4'd0 && $urandom_range(3) == 0) begin
         t = 4'($urandom_range(1, 15));
         if (t != ret_tag) begin
            Dmem2proc_tag = t;
            Dmem2proc_data = {$urandom, $urandom};
         end
      end
      if (proc2Dmem_command != 2'd0 && $urandom_range(2) != 0) begin
         Dmem2proc_response = tag_ctr;
         tr_q.push_back('{proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data});
         if (proc2Dmem_command == 2'd2) bk[proc2Dmem_addr] = proc2Dmem_data;
         else begin
            ret_tag = tag_ctr;
            ret_data = bk_get(proc2Dmem_addr);
            ret_cnt = force_lat != 0 ? force_lat : $urandom_range(1, 4);
         end
         tag_ctr = (tag_ctr == 4'd15) ? 4'd1 : tag_ctr + 4'd1;
      end
   endtask
   initial forever begin
      @(negedge clock);
      mem_step();
   end
   task automatic run(input string nm, input logic [1:0] c, input logic [31:0] a, input logic [1:0] s,
                      input logic [63:0] wd, input int hold, input logic eh, input logic [63:0] eo,
                      input int ntr, input tr_t e0, input tr_t e1);
      int lat;
      logic [63:0] o;
      logic v;
      @(negedge clock);
      tr_q.delete();
      proc2Dcache_command = c;
      proc2Dcache_addr = a;
      mem_size = s;
      proc2Dcache_data = wd;
      #1;
      lat = 0;
      while (!finished && lat < 100) begin
         @(negedge clock);
         #1;
         lat++;
      end
      if (!finished) begin
         chk({nm, "_timeout"}, 1, 0);
         return;
      end
      o = Dcache_data_out;
      v = Dcache_valid_out;
      chk({nm, "_hit"}, lat == 0, eh);
      chk({nm, "_out"}, o, eo);
      chk({nm, "_valid"}, v, c == 2'd1);
      repeat (hold + 1) @(posedge clock);
      #1;
      chk({nm, "_ntr"}, tr_q.size(), ntr);
      if (ntr > 0 && tr_q.size() > 0) chk({nm, "_tr0"}, tr_q[0], e0);
      if (ntr > 1 && tr_q.size() > 1) chk({nm, "_tr1"}, tr_q[1], e1);
   endtask
   initial begin
      vt[0]  = '{2'd2, 32'h010, 2'd3, 64'hFFFF_1234_4321_FFFF, 1'b0, 64'd0, 1,
                 '{2'd1, 32'h010, 64'd0}, '0, {2'b11, 24'h0, 64'hFFFF12344321FFFF}};
      vt[1]  = '{2'd2, 32'h810, 2'd3, 64'hABCD_0110_1001_ABCD, 1'b0, 64'd0, 2,
                 '{2'd2, 32'h010, 64'hFFFF12344321FFFF}, '{2'd1, 32'h810, 64'd0},
                 {2'b11, 24'h8, 64'hABCD01101001ABCD}};
      vt[2]  = '{2'd1, 32'h810, 2'd3, 64'd0, 1'b1, 64'hABCD01101001ABCD, 0, '0, '0,
                 {2'b11, 24'h8, 64'hABCD01101001ABCD}};
      vt[3]  = '{2'd1, 32'h010, 2'd3, 64'd0, 1'b0, 64'hFFFF12344321FFFF, 2,
                 '{2'd2, 32'h810, 64'hABCD01101001ABCD}, '{2'd1, 32'h010, 64'd0},
                 {2'b10, 24'h0, 64'hFFFF12344321FFFF}};
      vt[4]  = '{2'd2, 32'h013, 2'd0, 64'h1122_3344_5566_77AA, 1'b1, 64'd0, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[5]  = '{2'd1, 32'h010, 2'd3, 64'd0, 1'b1, 64'hFFFF1234AA21FFFF, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[6]  = '{2'd1, 32'h012, 2'd1, 64'd0, 1'b1, 64'h000000000000AA21, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[7]  = '{2'd1, 32'h013, 2'd1, 64'd0, 1'b1, 64'h000000000000AA21, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[8]  = '{2'd1, 32'h014, 2'd2, 64'd0, 1'b1, 64'h00000000FFFF1234, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[9]  = '{2'd1, 32'h017, 2'd0, 64'd0, 1'b1, 64'h00000000000000FF, 0, '0, '0,
                 {2'b11, 24'h0, 64'hFFFF1234AA21FFFF}};
      vt[10] = '{2'd2, 32'h016, 2'd1, 64'h0000_0000_1234_5678, 1'b1, 64'd0, 0, '0, '0,
                 {2'b11, 24'h0, 64'h56781234AA21FFFF}};
      vt[11] = '{2'd1, 32'h011, 2'd2, 64'd0, 1'b1, 64'h00000000AA21FFFF, 0, '0, '0,
                 {2'b11, 24'h0, 64'h56781234AA21FFFF}};
      vt[12] = '{2'd1, 32'h015, 2'd3, 64'd0, 1'b1, 64'h56781234AA21FFFF, 0, '0, '0,
                 {2'b11, 24'h0, 64'h56781234AA21FFFF}};
      #1;
      chk("reset_outputs", {proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, Dcache_data_out,
                            Dcache_valid_out, finished}, '0);
      chk("reset_lines", |show_dcache_data, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 13; k++) begin
         run($sformatf("vec%0d", k), vt[k].cmd, vt[k].addr, vt[k].size, vt[k].wd, k % 2,
             vt[k].hit, vt[k].out, vt[k].ntr, vt[k].t0, vt[k].t1);
         chk($sformatf("vec%0d_line", k), show_dcache_data[vt[k].addr[7:3]], vt[k].line);
      end
      // reset while the fill is outstanding
      begin
         int w = 0;
         @(negedge clock);
         force_lat = 8;
         tr_q.delete();
         proc2Dcache_command = 2'd1;
         proc2Dcache_addr = 32'h100;
         mem_size = 2'd3;
         #1;
         while (tr_q.size() == 0 && w < 100) begin
            @(negedge clock);
            #1;
            w++;
         end
         chk("rst_fetch_issued", tr_q.size(), 1);
         @(posedge clock);
         #2;
         reset = 1'b0;
         #1;
         chk("rst_mid_outputs", {proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, Dcache_data_out,
                                 Dcache_valid_out, finished}, '0);
         chk("rst_mid_lines", |show_dcache_data, 1'b0);
         @(negedge clock);
         proc2Dcache_command = 2'd0;
         #2;
         reset = 1'b1;
         repeat (12) @(negedge clock);
         #1;
         chk("rst_late_data_ignored", |show_dcache_data, 1'b0);
         chk("rst_idle_mem", proc2Dmem_command, 2'd0);
         force_lat = 0;
      end
      fm = bk;
      for (int k = 0; k < 32; k++) begin
         m_v[k] = 1'b0;
         m_d[k] = 1'b0;
         m_t[k] = '0;
      end
      for (int n = 0; n < 300; n++) begin
         logic [23:0] t;
         logic [4:0] i;
         logic [31:0] a, blk_a;
         logic [1:0] c, s;
         logic [63:0] wd, eo;
         logic h;
         int ntr;
         tr_t e0, e1;
         t = 24'($urandom_range(0, 3));
         i = 5'($urandom_range(0, 3));
         a = {t, i, 3'($urandom_range(0, 7))};
         blk_a = {t, i, 3'b000};
         c = 2'($urandom_range(1, 2));
         s = 2'($urandom_range(0, 3));
         wd = {$urandom, $urandom};
         h = m_v[i] && m_t[i] == t;
         ntr = 0;
         e0 = '0;
         e1 = '0;
         if (!h) begin
            if (m_v[i] && m_d[i]) begin
               e0 = '{2'd2, {m_t[i], i, 3'b000}, fm_get({m_t[i], i, 3'b000})};
               e1 = '{2'd1, blk_a, 64'd0};
               ntr = 2;
            end else begin
               e0 = '{2'd1, blk_a, 64'd0};
               ntr = 1;
            end
         end
         eo = (c == 2'd1) ? ref_load(a, s) : 64'd0;
         if (c == 2'd2) ref_store(a, s, wd);
         m_d[i] = (h && m_d[i]) || c == 2'd2;
         m_v[i] = 1'b1;
         m_t[i] = t;
         run($sformatf("rnd%0d", n), c, a, s, wd, $urandom_range(0, 1), h, eo, ntr, e0, e1);
         chk($sformatf("rnd%0d_line", n), show_dcache_data[i], {1'b1, m_d[i], m_t[i], fm_get(blk_a)});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the EX/memory stage and the 4-bit-tagged non-blocking data memory.
- Services one load or store at a time from the processor side.
- On a miss it writes back the dirty victim block, fetches the 64-bit block, installs it, then completes the request as a hit.

Parameters:
- XLEN, 32, address width.
- DCACHE_LINES, 32, number of lines; index width = log2(DCACHE_LINES) = 5.
- BLOCK_BYTES, 8, line size; offset width 3; tag width = XLEN-8 = 24.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Dmem2proc_response  in  4  nonzero = memory accepted this cycle's command; value is the transaction tag.
- Dmem2proc_data  in  64  load data returned by memory.
- Dmem2proc_tag  in  4  nonzero = Dmem2proc_data belongs to the transaction with this tag.
- proc2Dcache_addr  in  XLEN  byte address of the request.
- proc2Dcache_data  in  64  store data, right-aligned.
- proc2Dcache_command  in  2  0 none, 1 load, 2 store.
- mem_size  in  2  0 byte, 1 half, 2 word, 3 double.
- proc2Dmem_command  out  2  0 none, 1 load, 2 store.
- proc2Dmem_addr  out  XLEN  block address, low 3 bits always 0.
- proc2Dmem_data  out  64  writeback block data.
- Dcache_data_out  out  64  load result.
- Dcache_valid_out  out  1  Dcache_data_out valid.
- finished  out  1  current request completed.
- show_dcache_data  out  DCACHE_LINES x {valid, dirty, tags[23:0], data[63:0]}  debug view of the array; present in TEST_MODE only.

Behaviour:
- Address decode: offset = addr[2:0], index = addr[7:3], tag = addr[31:8].
- Reset (reset low, asynchronous):
  - all lines valid=0, dirty=0, tags=0, data=0;
  - FSM to IDLE; saved memory tag cleared to 0;
  - all outputs 0.
- Hit: line[index].valid && line[index].tags == tag && command != 0.
  - finished is combinational: finished = hit.
  - Dcache_valid_out = hit && command == load.
- Load hit, same cycle:
  - Dcache_data_out = (block >> (offset*8)), masked to the size width and zero-extended; the consumer sign-extends.
  - Otherwise Dcache_data_out = 0.
- Store hit:
  - On the clock edge, merge the size-wide low bytes of proc2Dcache_data into the block at the offset, and set dirty=1.
  - Repeating the same store while the request is held is idempotent.
- Alignment: offset bits below the access size are ignored (access forced to natural alignment).
- Requester protocol: holds command/addr/data/size stable until it samples finished=1; command 0 is idle.
- FSM states:
  - IDLE: on a miss with valid && dirty victim, go to WB; on a miss otherwise, go to FETCH.
  - WB: drive proc2Dmem_command=2, proc2Dmem_addr = {victim tag, index, 3'b0}, proc2Dmem_data = victim block. Hold until Dmem2proc_response != 0, then clear victim dirty and go to FETCH.
  - FETCH: drive command=1, addr = {tag, index, 3'b0}. Hold until response != 0, save response as the pending tag, go to WAIT.
  - WAIT: drive command=0. When Dmem2proc_tag == pending tag (nonzero), install line: valid=1, dirty=0, tags=tag, data=Dmem2proc_data. Clear pending tag and go to IDLE; the request hits on the next cycle.
- Outside WB/FETCH, proc2Dmem_command = 0 and addr/data = 0.
- Only one memory transaction is outstanding at a time.
- Memory tags not equal to the pending tag, and any tag while pending = 0, are ignored.
- If the request changes during WB/FETCH/WAIT, the operation in progress completes for the block latched on entry to WB/FETCH; the new request is evaluated in IDLE.
- Latency:
  - hit: 0 cycles;
  - clean miss: 1 + memory accept + memory data latency + 1;
  - dirty miss: adds WB accept cycles.
- Reset mid-miss: abandons the transaction; late memory responses are ignored.

Test Plan:
- Reset then ST 0x010, size 3, data FFFF_1234_4321_FFFF:
  - LOAD 0x010 is issued; after fill, finished=1;
  - line 2 valid=1, dirty=1, tags=0, data FFFF12344321FFFF.
- ST 0x810, size 3, data ABCD_0110_1001_ABCD:
  - STORE to 0x010 with FFFF12344321FFFF, then LOAD 0x810;
  - line 2 tags=0x000008, dirty=1, data ABCD01101001ABCD; finished=1.
- LD 0x810, size 3:
  - same-cycle hit, Dcache_valid_out=1, finished=1, data ABCD01101001ABCD;
  - proc2Dmem_command stays 0.
- LD 0x010, size 3:
  - writeback STORE 0x810 with ABCD01101001ABCD, then LOAD 0x010;
  - data_out FFFF12344321FFFF; line 2 dirty=0, tags=0.
- Sub-word access, after test 4:
  - ST 0x013, size 0, data 0xAA, then LD 0x010, size 3 → 0xFFFF1234AA21FFFF;
  - LD 0x012, size 1 → 0x000000000000AA21.
- Reset low during WAIT:
  - all lines invalid and outputs 0 immediately;
  - the subsequent memory data with the old tag is ignored.
